mod5_bit_tx: RTL and testbench

Serial transmitter for the mod-5 bit-stream protocol. It accepts a parallel word over a valid/ready handshake and emits it MSB-first, one bit per clock, with frame strobes. It also tracks the running residue mod 5 of the bits already sent. It sits on the driving side of the divisible-by-five serial checker and produces the stimulus stream that checker consumes; it can optionally append a tail that forces every frame to be a multiple of 5.

---
 rtl/mod5_pkg.sv | 25 ++
 rtl/mod5_residue_step.sv | 21 ++
 rtl/mod5_bit_tx.sv | 116 +++++++++++
 tb/tb_mod5_bit_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mod5_pkg.sv
// Shared definitions for the mod-5 bit-stream transmitter and checker.
// State encodings, the modulus and the tail lookup that zeroes a frame's residue.
package mod5_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;

    localparam logic [3:0] MOD5 = 4'd5;

    // Tail t = (2*r) mod 5, so that (value*8 + t) is divisible by five.
    function automatic logic [2:0] tail_lut(input logic [2:0] r);
        logic [2:0] t;
        case (r)
            3'd0:    t = 3'd0;
            3'd1:    t = 3'd2;
            3'd2:    t = 3'd4;
            3'd3:    t = 3'd1;
            3'd4:    t = 3'd3;
            default: t = 3'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mod5_residue_step.sv
// One step of the running residue: next = (2*residue + bit) mod 5, divider-free.
// Shared with the checker side of the link.
module mod5_residue_step
    import mod5_pkg::*;
(
    input  logic [2:0] residue,
    input  logic       bit_in,
    output logic [2:0] residue_next
);

    logic [3:0] sum;
    logic [3:0] reduced;

    // Residue is at most 4, so the sum is at most 9 and one subtraction suffices.
    always_comb begin
        sum          = {residue, 1'b0} + {3'd0, bit_in};
        reduced      = (sum >= MOD5) ? (sum - MOD5) : sum;
        residue_next = reduced[2:0];
    end

endmodule

// File: rtl/mod5_bit_tx.sv
// MSB-first serial transmitter with frame strobes and running residue mod 5.
// Define MOD5_TX_TAIL_EN to append a 3-bit tail making every frame divisible by five.
module mod5_bit_tx
    import mod5_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic [2:0]       residue,
    output logic             div5
);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [5:0]       cnt_reg;
    logic [2:0]       residue_reg;
    logic [2:0]       tail_reg;
    logic [2:0]       residue_next;
    logic             last_data;
    logic             load_fire;

    mod5_residue_step u_step (
        .residue      (residue_reg),
        .bit_in       (bit_out),
        .residue_next (residue_next)
    );

    always_comb begin
        bit_valid   = (state_reg != ST_IDLE);
        last_data   = (state_reg == ST_SHIFT) && (cnt_reg == 6'd0);
        frame_start = (state_reg == ST_SHIFT) && (cnt_reg == 6'(WIDTH - 1));
        bit_out     = 1'b0;
        if (state_reg == ST_SHIFT)
            bit_out = shreg_reg[WIDTH-1];
        else if (state_reg == ST_TAIL)
            bit_out = tail_reg[2];
`ifdef MOD5_TX_TAIL_EN
        frame_last  = (state_reg == ST_TAIL) && (cnt_reg == 6'd0);
`else
        frame_last  = last_data;
`endif
        residue     = bit_valid ? residue_next : 3'd0;
        div5        = frame_last && (residue == 3'd0);
        // Ready on the final frame bit lets frames run with zero gap.
        load_ready  = (state_reg == ST_IDLE) || frame_last;
        load_fire   = load_valid && load_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            shreg_reg   <= '0;
            cnt_reg     <= 6'd0;
            residue_reg <= 3'd0;
            tail_reg    <= 3'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_fire) begin
                        shreg_reg   <= load_data;
                        cnt_reg     <= 6'(WIDTH - 1);
                        residue_reg <= 3'd0;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg_reg   <= shreg_reg << 1;
                    residue_reg <= residue_next;
                    cnt_reg     <= cnt_reg - 6'd1;
                    if (last_data) begin
`ifdef MOD5_TX_TAIL_EN
                        tail_reg  <= tail_lut(residue_next);
                        cnt_reg   <= 6'd2;
                        state_reg <= ST_TAIL;
`else
                        if (load_fire) begin
                            shreg_reg   <= load_data;
                            cnt_reg     <= 6'(WIDTH - 1);
                            residue_reg <= 3'd0;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
`endif
                    end
                end
`ifdef MOD5_TX_TAIL_EN
                ST_TAIL: begin
                    tail_reg    <= tail_reg << 1;
                    residue_reg <= residue_next;
                    cnt_reg     <= cnt_reg - 6'd1;
                    if (cnt_reg == 6'd0) begin
                        if (load_fire) begin
                            shreg_reg   <= load_data;
                            cnt_reg     <= 6'(WIDTH - 1);
                            residue_reg <= 3'd0;
                            state_reg   <= ST_SHIFT;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod5_bit_tx.sv
// Directed bench for mod5_bit_tx: WIDTH=8 and WIDTH=1 instances, either tail build.
module tb_mod5_bit_tx;

`ifdef MOD5_TX_TAIL_EN
    localparam int TAIL_ON = 1;
`else
    localparam int TAIL_ON = 0;
`endif
    localparam int FLEN = 8 + 3 * TAIL_ON;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready, bit_out, bit_valid, frame_start, frame_last, div5;
    logic [2:0] residue;

    logic       l1_valid = 1'b0;
    logic [0:0] l1_data = 1'b0;
    logic       l1_ready, l1_bit, l1_bvalid, l1_start, l1_last, l1_div5;
    logic [2:0] l1_res;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod5_bit_tx #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .bit_out(bit_out), .bit_valid(bit_valid),
        .frame_start(frame_start), .frame_last(frame_last), .residue(residue), .div5(div5)
    );

    mod5_bit_tx #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(l1_valid), .load_ready(l1_ready),
        .load_data(l1_data), .bit_out(l1_bit), .bit_valid(l1_bvalid),
        .frame_start(l1_start), .frame_last(l1_last), .residue(l1_res), .div5(l1_div5)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] d);
        load_data  = d;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    // Checks a whole frame whose MSB is currently on bit_out. Optionally chains
    // the next word on the last bit, or pulses a stray load mid-frame.
    task automatic frame8(input logic [7:0] d, input logic [2:0] tail_exp,
                          input int fin_res, input int fin_div5,
                          input logic chain, input logic [7:0] nd, input logic stray);
        int r = 0;
        int b;
        logic last;
        for (int i = 0; i < FLEN; i++) begin
            b    = (i < 8) ? int'(d[7-i]) : int'(tail_exp[2-(i-8)]);
            r    = (2 * r + b) % 5;
            last = (i == FLEN - 1);
            check("bit_valid", bit_valid, 1);
            check("bit_out", bit_out, b);
            check("residue", residue, r);
            check("frame_start", frame_start, int'(i == 0));
            check("frame_last", frame_last, int'(last));
            check("load_ready", load_ready, int'(last));
            check("div5", div5, int'(last && r == 0));
            if (last) begin
                check("final_residue", residue, fin_res);
                check("final_div5", div5, fin_div5);
            end
            if (chain && last) begin
                load_data  = nd;
                load_valid = 1'b1;
            end
            if (stray && i == 3) begin
                load_data  = 8'h33;
                load_valid = 1'b1;
            end
            step();
            load_valid = 1'b0;
        end
        $display("frame 0x%02h done, final residue %0d", d, r);
        if (!chain) begin
            check("idle_valid", bit_valid, 0);
            check("idle_residue", residue, 0);
            check("idle_ready", load_ready, 1);
        end
    endtask

    initial begin
        repeat (2) step();
        check("rst_ready", load_ready, 1);
        check("rst_valid", bit_valid, 0);
        check("rst_bit", bit_out, 0);
        check("rst_start", frame_start, 0);
        check("rst_last", frame_last, 0);
        check("rst_residue", residue, 0);
        check("rst_div5", div5, 0);
        rst_n = 1'b1;
        step();

        // 0x0A: residues 0,0,0,0,1,2,0,0; tail 000 keeps residue 0
        load8(8'h0A);
        frame8(8'h0A, 3'b000, 0, 1, 1'b0, 8'h00, 1'b0);

        // 0x07: residue 2 plain; tail 100 (value 60) gives 0
        load8(8'h07);
        frame8(8'h07, 3'b100, TAIL_ON ? 0 : 2, TAIL_ON, 1'b0, 8'h00, 1'b0);

        // 0x05 then 0x0F back-to-back, both divisible by five
        load8(8'h05);
        frame8(8'h05, 3'b000, 0, 1, 1'b1, 8'h0F, 1'b0);
        frame8(8'h0F, 3'b000, 0, 1, 1'b0, 8'h00, 1'b0);

        // Stray load of 0x33 mid-frame is ignored
        load8(8'h0A);
        frame8(8'h0A, 3'b000, 0, 1, 1'b0, 8'h00, 1'b1);
        step();
        check("no_extra_frame", bit_valid, 0);

        // Reset on the 3rd bit of 0xFF aborts the frame
        load8(8'hFF);
        check("ff_bit1", bit_out, 1);
        step();
        check("ff_bit2", bit_out, 1);
        step();
        check("ff_bit3", bit_out, 1);
        check("ff_res3", residue, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_valid", bit_valid, 0);
        check("abort_residue", residue, 0);
        check("abort_ready", load_ready, 1);
        check("abort_last", frame_last, 0);
        $display("frame 0xFF aborted by reset");
        load8(8'h01);
        frame8(8'h01, 3'b010, TAIL_ON ? 0 : 1, TAIL_ON, 1'b0, 8'h00, 1'b0);

        // WIDTH=1, load 1: start and last together without tail
        l1_data  = 1'b1;
        l1_valid = 1'b1;
        step();
        l1_valid = 1'b0;
        check("w1_valid", l1_bvalid, 1);
        check("w1_bit", l1_bit, 1);
        check("w1_start", l1_start, 1);
        check("w1_last", l1_last, 1 - TAIL_ON);
        check("w1_residue", l1_res, 1);
        check("w1_div5", l1_div5, 0);
        step();
        if (TAIL_ON != 0) begin
            // tail for r=1 is 010: residues 2,0,0
            check("w1_t0", l1_bit, 0);
            check("w1_t0_res", l1_res, 2);
            step();
            check("w1_t1", l1_bit, 1);
            check("w1_t1_res", l1_res, 0);
            step();
            check("w1_t2_last", l1_last, 1);
            check("w1_t2_div5", l1_div5, 1);
            step();
        end
        check("w1_idle", l1_bvalid, 0);
        check("w1_ready", l1_ready, 1);
        $display("frame w1 0x1 done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
